evt_monitor: RTL and testbench
==============================

EVT_MONITOR -- requirements
Module: evt_monitor

Interface
REQ-001 SHALL have parameter DEPTH, default 4: capture FIFO depth in entries, power of two, 2 to 16.
REQ-002 SHALL have parameter CNT_W, default 16: width of every counter output.
REQ-003 SHALL have parameter EXP_COUNT, default 20: number of accepted events after which the block reports done.
REQ-004 SHALL have port clk, input, 1: single clock; all logic samples on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port en, input, 1: monitoring enable.
REQ-007 SHALL have port clr, input, 1: synchronous clear of counters, FIFO and state.
REQ-008 SHALL have port evt, input, 1: event strobe, one sample per high cycle.
REQ-009 SHALL have port val, input, 8: data qualified by evt.
REQ-010 SHALL have port flag, input, 1: parity flag qualified by evt.
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_val (output, 8) and out_flag (output, 1): capture readout handshake and data.
REQ-012 SHALL have outputs trig_count, seq_err_count and flag_err_count, each CNT_W wide.
REQ-013 SHALL have outputs done (1) and overflow (1).

Function
REQ-014 SHALL use FSM states IDLE, FIRST, RUN and DONE.
REQ-015 SHALL make these transitions: IDLE->FIRST on en=1; FIRST->RUN on the first accepted event; RUN->DONE when trig_count reaches EXP_COUNT; any state->IDLE on en=0, with counters and FIFO held.
REQ-016 SHALL accept an event only when evt=1 in state FIRST or RUN; in IDLE and DONE, evt SHALL be ignored.
REQ-017 SHALL increment trig_count by 1 on each accepted event, saturating at all-ones; the new value is visible in the cycle after acceptance.
REQ-018 SHALL increment flag_err_count on an accepted event where flag != (val[0]==0).
REQ-019 SHALL, in RUN only, increment seq_err_count when val != (prev_val+1) mod 256; 255->0 is legal; FIRST performs no sequence check.
REQ-020 SHALL update prev_val to val on every accepted event, including ones with errors.
REQ-021 SHALL let both error counters increment in the same cycle, each saturating.
REQ-022 SHALL push {val,flag} into the FIFO on each accepted event.
REQ-023 SHALL, when the FIFO is full and no pop occurs that cycle, drop the push and set overflow, which is sticky until clr or reset.
REQ-024 SHALL, on simultaneous push and pop when full, perform both without setting overflow.
REQ-025 SHALL drive out_valid = FIFO not empty, with out_val and out_flag taken from the head; a pop occurs on out_valid && out_ready, and a pop while empty has no effect.
REQ-026 SHALL hold out_val and out_flag stable while out_valid=1 and out_ready=0.
REQ-027 SHALL drive done=1 exactly while in state DONE.
REQ-028 SHALL make clr=1 zero all counters, empty the FIFO, clear overflow and force IDLE next cycle; clr takes priority over evt in the same cycle.
REQ-029 SHALL, when the EXP_COUNT-th event is accepted, count and push it, with done rising the following cycle.

Reset
REQ-030 SHALL, on rst_n=0 at a clock edge, set state IDLE, all counters 0, prev_val 0, FIFO empty, out_valid 0, out_val 0, out_flag 0, done 0 and overflow 0.
REQ-031 SHALL have reset override clr, en and evt, and SHALL leave no stale FIFO entries after a reset applied mid-operation.

Structure
REQ-032 SHALL place in shared package evt_mon_pkg: the state enum, the sample struct {val[7:0], flag} and default parameter constants.
REQ-033 SHALL implement the FIFO as sub-module evt_mon_fifo, parameterised by DEPTH, with push, pop, full, empty and flush ports.

Verification
REQ-034 SHALL cover: en=1, 10 events with val 1..10 and correct flags, out_ready=0 -> trig_count=10, both error counters 0, FIFO holds 1..4, overflow=1.
REQ-035 SHALL cover: events with val 254, 255, 0, 1 and correct flags -> seq_err_count=0 (wrap-around legal).
REQ-036 SHALL cover: event with val=5, flag=1 -> flag_err_count=1; then val=6, flag=1 -> flag_err_count stays 1.
REQ-037 SHALL cover: sequence 3, 7, 8 -> seq_err_count=1 and prev_val=8.
REQ-038 SHALL cover: 21 events with EXP_COUNT=20 -> done=1 and trig_count=20; the 21st event is neither counted nor pushed.
REQ-039 SHALL cover: rst_n=0 for one cycle in RUN with 3 FIFO entries -> all outputs zero and out_valid=0 next cycle; a subsequent first event is not sequence-checked.

Source files
------------

// File: rtl/evt_mon_pkg.sv
// Shared types and default parameters for the event monitor and its capture FIFO.
package evt_mon_pkg;

  typedef enum logic [1:0] {IDLE, FIRST, RUN, DONE} state_t;

  typedef struct packed {
    logic [7:0] val;
    logic       flag;
  } sample_t;

  localparam int SAMPLE_W      = $bits(sample_t);
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_EXP_COUNT = 20;

endpackage

// File: rtl/evt_mon_fifo.sv
// Capture FIFO for accepted samples: power-of-two depth, show-ahead head output,
// push-while-full accepted only when a pop frees a slot in the same cycle.
module evt_mon_fifo
  import evt_mon_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                push,
  input  logic                pop,
  input  logic [SAMPLE_W-1:0] wdata,
  output logic [SAMPLE_W-1:0] rdata,
  output logic                full,
  output logic                empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr_reg;
  logic [AW-1:0]       rd_ptr_reg;
  logic [AW:0]         count_reg;
  logic                do_push;
  logic                do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head reads as zero when empty so no stale entry is ever visible.
  assign rdata   = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

endmodule

// File: rtl/evt_monitor.sv
// Event monitor: counts accepted strobes, checks sequence and parity flag,
// captures samples into a FIFO and reports done after EXP_COUNT events.
module evt_monitor
  import evt_mon_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int EXP_COUNT = DEF_EXP_COUNT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             evt,
  input  logic [7:0]       val,
  input  logic             flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_val,
  output logic             out_flag,
  output logic [CNT_W-1:0] trig_count,
  output logic [CNT_W-1:0] seq_err_count,
  output logic [CNT_W-1:0] flag_err_count,
  output logic             done,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg;
  logic [7:0]       prev_val_reg;
  logic [CNT_W-1:0] trig_count_reg;
  logic [CNT_W-1:0] seq_err_count_reg;
  logic [CNT_W-1:0] flag_err_count_reg;
  logic             overflow_reg;
  logic             done_reg;

  sample_t          push_s;
  sample_t          head_s;
  logic             fifo_full;
  logic             fifo_empty;
  logic             accept;
  logic             pop;
  logic             seq_bad;
  logic             flag_bad;
  logic             reach;
  logic [CNT_W-1:0] trig_next;

  assign push_s.val  = val;
  assign push_s.flag = flag;

  assign accept    = en && evt && (state_reg == FIRST || state_reg == RUN);
  assign pop       = !fifo_empty && out_ready;
  assign seq_bad   = (state_reg == RUN) && (val != prev_val_reg + 8'd1);
  // A correct flag is set exactly when val is even.
  assign flag_bad  = (flag != ~val[0]);
  assign trig_next = (trig_count_reg == CNT_MAX) ? trig_count_reg : trig_count_reg + 1'b1;
  assign reach     = (32'(trig_next) >= EXP_COUNT);

  evt_mon_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clr),
    .push  (accept),
    .pop   (pop),
    .wdata (push_s),
    .rdata (head_s),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state_reg          <= IDLE;
      prev_val_reg       <= '0;
      trig_count_reg     <= '0;
      seq_err_count_reg  <= '0;
      flag_err_count_reg <= '0;
      overflow_reg       <= 1'b0;
      done_reg           <= 1'b0;
    end else begin
      if (accept) begin
        trig_count_reg <= trig_next;
        prev_val_reg   <= val;
        if (seq_bad && seq_err_count_reg != CNT_MAX)
          seq_err_count_reg <= seq_err_count_reg + 1'b1;
        if (flag_bad && flag_err_count_reg != CNT_MAX)
          flag_err_count_reg <= flag_err_count_reg + 1'b1;
      end
      if (accept && fifo_full && !pop) overflow_reg <= 1'b1;

      // Dropping en parks the FSM but keeps counters and captured data.
      if (!en) begin
        state_reg <= IDLE;
        done_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE:  state_reg <= FIRST;
          FIRST, RUN: begin
            if (accept) begin
              if (reach) begin
                state_reg <= DONE;
                done_reg  <= 1'b1;
              end else begin
                state_reg <= RUN;
              end
            end
          end
          DONE:    state_reg <= DONE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign out_valid      = !fifo_empty;
  assign out_val        = head_s.val;
  assign out_flag       = head_s.flag;
  assign trig_count     = trig_count_reg;
  assign seq_err_count  = seq_err_count_reg;
  assign flag_err_count = flag_err_count_reg;
  assign done           = done_reg;
  assign overflow       = overflow_reg;

endmodule

// File: tb/tb_evt_monitor.sv
// Bench for evt_monitor: directed scenarios plus random traffic, all checked
// against a behavioural model with a queue-based capture scoreboard.
module tb_evt_monitor;

  localparam int DEPTH     = 4;
  localparam int CNT_W     = 16;
  localparam int EXP_COUNT = 20;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             clr;
  logic             evt;
  logic [7:0]       val;
  logic             flag;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_val;
  logic             out_flag;
  logic [CNT_W-1:0] trig_count;
  logic [CNT_W-1:0] seq_err_count;
  logic [CNT_W-1:0] flag_err_count;
  logic             done;
  logic             overflow;

  evt_monitor #(.DEPTH(DEPTH), .CNT_W(CNT_W), .EXP_COUNT(EXP_COUNT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .clr            (clr),
    .evt            (evt),
    .val            (val),
    .flag           (flag),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_val        (out_val),
    .out_flag       (out_flag),
    .trig_count     (trig_count),
    .seq_err_count  (seq_err_count),
    .flag_err_count (flag_err_count),
    .done           (done),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: listening once en has been high for a cycle,
  // sequence checking only after the first event since enabling.
  int unsigned m_trig, m_seq, m_ferr;
  bit          m_live, m_seen, m_done, m_ovf;
  logic [7:0]  m_prev;
  logic [7:0]  m_nxt;
  logic [8:0]  exp_q[$];
  bit          m_popped;

  function automatic int unsigned sat_inc(input int unsigned x);
    return (x >= (1 << CNT_W) - 1) ? x : x + 1;
  endfunction

  // Single process: compare outputs against the model, pop the scoreboard on
  // a handshake, then advance the model with the inputs for the next edge.
  always @(negedge clk) begin
    m_popped = 0;
    if (chk_en) begin
      check("out_valid", out_valid, exp_q.size() != 0);
      check("trig_count", trig_count, m_trig);
      check("seq_err_count", seq_err_count, m_seq);
      check("flag_err_count", flag_err_count, m_ferr);
      check("done", done, m_done);
      check("overflow", overflow, m_ovf);
    end
    if (out_valid === 1'b1 && exp_q.size() != 0) begin
      if (chk_en) check("out_data", {out_val, out_flag}, exp_q[0]);
      if (out_ready) begin
        exp_q.delete(0);
        m_popped = 1;
      end
    end
    if (!rst_n || clr) begin
      m_trig = 0; m_seq = 0; m_ferr = 0;
      m_live = 0; m_seen = 0; m_done = 0; m_ovf = 0;
      m_prev = 0;
      exp_q.delete();
    end else if (!en) begin
      m_live = 0; m_seen = 0; m_done = 0;
    end else begin
      if (evt && m_live && !m_done) begin
        m_trig = sat_inc(m_trig);
        m_nxt  = m_prev + 8'd1;
        if (m_seen && val != m_nxt) m_seq = sat_inc(m_seq);
        if (flag == val[0]) m_ferr = sat_inc(m_ferr);
        m_prev = val;
        m_seen = 1;
        if (!m_popped && exp_q.size() == DEPTH) m_ovf = 1;
        else exp_q.push_back({val, flag});
        if (m_trig >= EXP_COUNT) m_done = 1;
      end
      m_live = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v, input logic f);
    evt = 1'b1; val = v; flag = f;
    tick();
    evt = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1; tick(); clr = 1'b0; tick();
  endtask

  logic [7:0] last_v;
  logic [7:0] rv;

  initial begin
    rst_n = 0; en = 0; clr = 0; evt = 0; val = 0; flag = 0; out_ready = 0;
    tick();
    chk_en = 1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_val", out_val, 0);
    check("reset_trig", trig_count, 0);
    rst_n = 1;
    tick();

    // Ten in-order events with the reader stalled: FIFO keeps 1..4 and overflows.
    en = 1; tick();
    for (int v = 1; v <= 10; v++) send(8'(v), ~v[0]);
    check("s1_trig", trig_count, 10);
    check("s1_seq", seq_err_count, 0);
    check("s1_flag", flag_err_count, 0);
    check("s1_overflow", overflow, 1);
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      check("s1_fifo_head", out_val, i);
      tick();
    end
    check("s1_drained", out_valid, 0);

    // Wrap-around of the sequence is legal.
    do_clr();
    check("clr_overflow", overflow, 0);
    send(8'd254, 1'b1); send(8'd255, 1'b0); send(8'd0, 1'b1); send(8'd1, 1'b0);
    check("s2_seq_wrap", seq_err_count, 0);

    do_clr();
    send(8'd5, 1'b1);
    check("s3_flag_err", flag_err_count, 1);
    send(8'd6, 1'b1);
    check("s3_flag_hold", flag_err_count, 1);

    do_clr();
    send(8'd3, 1'b0); send(8'd7, 1'b0); send(8'd8, 1'b1);
    check("s4_seq_err", seq_err_count, 1);
    send(8'd9, 1'b0);
    check("s4_prev_is_8", seq_err_count, 1);

    // Twenty-one events: the last arrives in DONE and is ignored.
    do_clr();
    for (int i = 0; i < 21; i++) send(8'(100 + i), ~i[0]);
    check("s5_trig", trig_count, EXP_COUNT);
    check("s5_done", done, 1);

    // Reset in the middle of a run with three captured entries.
    out_ready = 0;
    do_clr();
    send(8'd1, 1'b0); send(8'd2, 1'b1); send(8'd3, 1'b0);
    check("s6_valid_before", out_valid, 1);
    rst_n = 0; tick(); rst_n = 1;
    check("s6_valid_after", out_valid, 0);
    check("s6_out_val", out_val, 0);
    check("s6_trig", trig_count, 0);
    check("s6_done", done, 0);
    tick();
    send(8'd77, 1'b0);
    check("s6_first_unchecked", seq_err_count, 0);
    check("s6_trig_one", trig_count, 1);

    // Random traffic.
    last_v = 8'd77;
    for (int c = 0; c < 3000; c++) begin
      en        = ($urandom % 16) != 0;
      clr       = ($urandom % 64) == 0;
      rst_n     = ($urandom % 300) != 0;
      out_ready = ($urandom % 4) != 0;
      evt       = ($urandom % 2) != 0;
      rv        = 8'($urandom);
      val       = (($urandom % 4) == 0) ? rv : last_v + 8'd1;
      flag      = (($urandom % 8) == 0) ? val[0] : ~val[0];
      if (evt) last_v = val;
      tick();
    end
    rst_n = 1; clr = 0; evt = 0; en = 0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
